// File: rtl/flags_register_if.sv
// Bus between the microcode sequencer/ALU and the architectural FLAGS register.
// The master side drives the update controls; the slave side is the register itself.
interface flags_register_if;
    logic [15:0] alu_flags;
    logic        alu_update;
    logic [15:0] update_mask;
    logic        load;
    logic [15:0] load_val;
    logic        set_en;
    logic [2:0]  set_op;
    logic        ss_load;
    logic        insn_retire;
    logic        trap_ack;
    logic [3:0]  cond;
    logic [15:0] flags;
    logic        cond_true;
    logic        int_enabled;
    logic        trap_pending;

    modport master (
        output alu_flags, alu_update, update_mask, load, load_val,
               set_en, set_op, ss_load, insn_retire, trap_ack, cond,
        input  flags, cond_true, int_enabled, trap_pending
    );

    modport slave (
        input  alu_flags, alu_update, update_mask, load, load_val,
               set_en, set_op, ss_load, insn_retire, trap_ack, cond,
        output flags, cond_true, int_enabled, trap_pending
    );
endinterface

// File: rtl/flags_register.sv
// Architectural 8086 FLAGS register.
// Merges ALU flag results under a mask, handles full loads and the flag set/clear
// instructions, evaluates Jcc conditions and tracks the interrupt shadow and the
// single-step trap request.
module flags_register #(
    parameter logic [15:0] RESET_FLAGS = 16'hF002
) (
    input  logic             clk,
    input  logic             reset_n,
    flags_register_if.slave  bus
);

    // Bits 15:12 and 1 are hardwired to 1, bits 5 and 3 to 0.
    localparam logic [15:0] FORCE_ONE   = 16'hF002;
    localparam logic [15:0] FORCE_ZERO  = 16'h0028;
    localparam logic [15:0] RESET_VALUE = (RESET_FLAGS | FORCE_ONE) & ~FORCE_ZERO;

    localparam int CF_BIT = 0;
    localparam int PF_BIT = 2;
    localparam int ZF_BIT = 6;
    localparam int SF_BIT = 7;
    localparam int TF_BIT = 8;
    localparam int IF_BIT = 9;
    localparam int DF_BIT = 10;
    localparam int OF_BIT = 11;

    typedef enum logic [2:0] {
        OP_CLC  = 3'd0,
        OP_STC  = 3'd1,
        OP_CLI  = 3'd2,
        OP_STI  = 3'd3,
        OP_CLD  = 3'd4,
        OP_STD  = 3'd5,
        OP_NOP6 = 3'd6,
        OP_NOP7 = 3'd7
    } set_op_t;

    logic [15:0] flags_q;
    logic [15:0] flags_next;
    logic [15:0] merged;
    logic [1:0]  shadow;
    logic [1:0]  shadow_next;
    logic        tf_armed;
    logic        trap_pending_q;
    logic        set_active;
    logic        sti_from_clear;
    logic        cli_now;
    logic        cond_base;
    set_op_t     op;

    assign op         = set_op_t'(bus.set_op);
    assign set_active = bus.set_en & ~bus.load;

    // Next FLAGS value: load wins outright, otherwise ALU merge followed by the set/clear op.
    always_comb begin
        merged = flags_q;
        if (bus.alu_update) begin
            merged = (flags_q & ~bus.update_mask) | (bus.alu_flags & bus.update_mask);
        end
        if (bus.set_en) begin
            case (op)
                OP_CLC:  merged[CF_BIT] = 1'b0;
                OP_STC:  merged[CF_BIT] = 1'b1;
                OP_CLI:  merged[IF_BIT] = 1'b0;
                OP_STI:  merged[IF_BIT] = 1'b1;
                OP_CLD:  merged[DF_BIT] = 1'b0;
                OP_STD:  merged[DF_BIT] = 1'b1;
                default: merged = merged;
            endcase
        end
        flags_next = bus.load ? bus.load_val : merged;
        flags_next = (flags_next | FORCE_ONE) & ~FORCE_ZERO;
    end

    // Shadow counter: STI-from-clear and MOV/POP SS arm it, CLI kills it, retirements drain it.
    always_comb begin
        sti_from_clear = set_active & (op == OP_STI) & ~flags_q[IF_BIT];
        cli_now        = set_active & (op == OP_CLI);
        shadow_next    = shadow;
        if (bus.ss_load || sti_from_clear) begin
            shadow_next = 2'd2;
        end else if (cli_now) begin
            shadow_next = 2'd0;
        end else if (bus.insn_retire && (shadow != 2'd0)) begin
            shadow_next = shadow - 2'd1;
        end
    end

    // FLAGS and shadow state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= RESET_VALUE;
            shadow  <= 2'd0;
        end else begin
            flags_q <= flags_next;
            shadow  <= shadow_next;
        end
    end

    // Single-step: arm from the TF seen by the retiring instruction, raise the trap one instruction later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tf_armed       <= 1'b0;
            trap_pending_q <= 1'b0;
        end else begin
            if (bus.insn_retire) begin
                tf_armed <= flags_q[TF_BIT];
            end
            if (bus.trap_ack) begin
                trap_pending_q <= 1'b0;
            end else if (bus.insn_retire && tf_armed && (shadow == 2'd0)) begin
                trap_pending_q <= 1'b1;
            end
        end
    end

    // Jcc evaluation: odd condition codes are the negation of the even code below them.
    always_comb begin
        cond_base = 1'b0;
        case (bus.cond[3:1])
            3'd0:    cond_base = flags_q[OF_BIT];
            3'd1:    cond_base = flags_q[CF_BIT];
            3'd2:    cond_base = flags_q[ZF_BIT];
            3'd3:    cond_base = flags_q[CF_BIT] | flags_q[ZF_BIT];
            3'd4:    cond_base = flags_q[SF_BIT];
            3'd5:    cond_base = flags_q[PF_BIT];
            3'd6:    cond_base = flags_q[SF_BIT] ^ flags_q[OF_BIT];
            default: cond_base = flags_q[ZF_BIT] | (flags_q[SF_BIT] ^ flags_q[OF_BIT]);
        endcase
    end

    assign bus.flags        = flags_q;
    assign bus.cond_true    = cond_base ^ bus.cond[0];
    assign bus.int_enabled  = flags_q[IF_BIT] & (shadow == 2'd0);
    assign bus.trap_pending = trap_pending_q;

endmodule

// File: tb/tb_flags_register.sv
// Self-checking bench for flags_register: hand-written corner sequences, a table of
// load/condition vectors and randomized traffic, all compared against a behavioural model.
module tb_flags_register;

    logic clk = 1'b0;
    logic reset_n;

    flags_register_if bus();

    flags_register #(.RESET_FLAGS(16'hF002)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [15:0] m_flags;
    int          m_shadow;
    logic        m_armed;
    logic        m_pend;

    typedef struct {
        logic [15:0] load_val;
        logic [3:0]  cond;
        logic [15:0] exp_flags;
        logic        exp_cond;
    } vec_t;

    vec_t vecs[$];

    // Jcc rule written directly from the named flags.
    function automatic logic modelCond(input logic [15:0] f, input logic [3:0] c);
        logic cf, pf, zf, sf, of, lt;
        cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of = f[11];
        lt = (sf != of);
        case (c)
            4'h0: return of;
            4'h1: return !of;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return zf;
            4'h5: return !zf;
            4'h6: return cf || zf;
            4'h7: return !(cf || zf);
            4'h8: return sf;
            4'h9: return !sf;
            4'hA: return pf;
            4'hB: return !pf;
            4'hC: return lt;
            4'hD: return !lt;
            4'hE: return zf || lt;
            default: return !(zf || lt);
        endcase
    endfunction

    task automatic modelReset();
        m_flags  = 16'hF002;
        m_shadow = 0;
        m_armed  = 1'b0;
        m_pend   = 1'b0;
    endtask

    task automatic clearInputs();
        bus.alu_flags   = 16'h0000;
        bus.alu_update  = 1'b0;
        bus.update_mask = 16'h0000;
        bus.load        = 1'b0;
        bus.load_val    = 16'h0000;
        bus.set_en      = 1'b0;
        bus.set_op      = 3'd0;
        bus.ss_load     = 1'b0;
        bus.insn_retire = 1'b0;
        bus.trap_ack    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Compare every output against the model.
    task automatic checkModel(input string tag);
        checkOutput({tag, ".flags"}, bus.flags, m_flags);
        checkOutput({tag, ".cond_true"}, {15'd0, bus.cond_true}, {15'd0, modelCond(m_flags, bus.cond)});
        checkOutput({tag, ".int_enabled"}, {15'd0, bus.int_enabled}, {15'd0, m_flags[9] && (m_shadow == 0)});
        checkOutput({tag, ".trap_pending"}, {15'd0, bus.trap_pending}, {15'd0, m_pend});
    endtask

    // Advance the model over one clock edge with the currently driven inputs, then clear the pulses.
    task automatic applyStimulus();
        logic [15:0] nf;
        int          ns;
        logic        na, np;
        nf = m_flags;
        if (bus.load) begin
            nf = bus.load_val;
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (bus.alu_update && bus.update_mask[b]) nf[b] = bus.alu_flags[b];
            end
            if (bus.set_en) begin
                case (bus.set_op)
                    3'd0: nf[0]  = 1'b0;
                    3'd1: nf[0]  = 1'b1;
                    3'd2: nf[9]  = 1'b0;
                    3'd3: nf[9]  = 1'b1;
                    3'd4: nf[10] = 1'b0;
                    3'd5: nf[10] = 1'b1;
                    default: ;
                endcase
            end
        end
        nf = (nf | 16'hF002) & ~16'h0028;

        ns = m_shadow;
        if (bus.insn_retire && ns > 0) ns = ns - 1;
        if (!bus.load && bus.set_en && bus.set_op == 3'd2) ns = 0;
        if (bus.ss_load || (!bus.load && bus.set_en && bus.set_op == 3'd3 && !m_flags[9])) ns = 2;

        na = bus.insn_retire ? m_flags[8] : m_armed;
        np = m_pend;
        if (bus.insn_retire && m_armed && m_shadow == 0) np = 1'b1;
        if (bus.trap_ack) np = 1'b0;

        @(posedge clk);
        #1;
        m_flags  = nf;
        m_shadow = ns;
        m_armed  = na;
        m_pend   = np;
        clearInputs();
    endtask

    task automatic doLoad(input logic [15:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        applyStimulus();
    endtask

    task automatic doSet(input logic [2:0] op);
        bus.set_en = 1'b1;
        bus.set_op = op;
        applyStimulus();
    endtask

    task automatic doRetire();
        bus.insn_retire = 1'b1;
        applyStimulus();
    endtask

    initial begin
        reset_n = 1'b0;
        bus.cond = 4'h0;
        clearInputs();
        modelReset();
        #12;
        reset_n = 1'b1;
        #1;

        // Reset state and reserved bits.
        checkOutput("reset_flags", bus.flags, 16'hF002);
        checkOutput("reset_int_enabled", {15'd0, bus.int_enabled}, 16'd0);
        checkOutput("reset_trap", {15'd0, bus.trap_pending}, 16'd0);
        checkModel("reset");
        doLoad(16'h0000);
        checkOutput("load_zero_reserved", bus.flags, 16'hF002);

        // Masked ALU merge and condition evaluation.
        bus.alu_update  = 1'b1;
        bus.alu_flags   = 16'h08C5;
        bus.update_mask = 16'h08D5;
        applyStimulus();
        checkOutput("alu_merge", bus.flags, 16'hF8C7);
        bus.cond = 4'h4; #1;
        checkOutput("cond_zf", {15'd0, bus.cond_true}, 16'd1);
        bus.cond = 4'hC; #1;
        checkOutput("cond_lt", {15'd0, bus.cond_true}, 16'd0);
        checkModel("merge");

        // ALU merge and STC in the same cycle, then load beats both.
        bus.alu_update  = 1'b1;
        bus.alu_flags   = 16'h0000;
        bus.update_mask = 16'h0001;
        bus.set_en      = 1'b1;
        bus.set_op      = 3'd1;
        applyStimulus();
        checkOutput("stc_over_alu", bus.flags, 16'hF8C7);
        bus.alu_update  = 1'b1;
        bus.alu_flags   = 16'hFFFF;
        bus.update_mask = 16'hFFFF;
        bus.set_en      = 1'b1;
        bus.set_op      = 3'd1;
        bus.load        = 1'b1;
        bus.load_val    = 16'h0000;
        applyStimulus();
        checkOutput("load_priority", bus.flags, 16'hF002);
        checkModel("priority");

        // Interrupt shadow after STI and MOV SS.
        doSet(3'd3);
        checkOutput("sti_flags", bus.flags, 16'hF202);
        checkOutput("sti_shadow0", {15'd0, bus.int_enabled}, 16'd0);
        doRetire();
        checkOutput("sti_shadow1", {15'd0, bus.int_enabled}, 16'd0);
        doRetire();
        checkOutput("sti_shadow_done", {15'd0, bus.int_enabled}, 16'd1);
        doSet(3'd3);
        checkOutput("sti_when_set", {15'd0, bus.int_enabled}, 16'd1);
        bus.ss_load = 1'b1;
        applyStimulus();
        checkOutput("ss_shadow0", {15'd0, bus.int_enabled}, 16'd0);
        doRetire();
        checkOutput("ss_shadow1", {15'd0, bus.int_enabled}, 16'd0);
        doRetire();
        checkOutput("ss_shadow_done", {15'd0, bus.int_enabled}, 16'd1);
        doSet(3'd2);
        doSet(3'd3);
        doRetire();
        checkOutput("mid_shadow", {15'd0, bus.int_enabled}, 16'd0);
        doSet(3'd2);
        checkOutput("cli_flags", bus.flags, 16'hF002);
        checkOutput("cli_int", {15'd0, bus.int_enabled}, 16'd0);
        doLoad(16'h0200);
        checkOutput("load_if_no_shadow", {15'd0, bus.int_enabled}, 16'd1);
        checkModel("shadow");
        doLoad(16'h0000);

        // Single-step trap.
        doLoad(16'hF102);
        checkOutput("tf_loaded", bus.flags, 16'hF102);
        doRetire();
        checkOutput("trap_first_retire", {15'd0, bus.trap_pending}, 16'd0);
        doRetire();
        checkOutput("trap_second_retire", {15'd0, bus.trap_pending}, 16'd1);
        bus.trap_ack = 1'b1;
        applyStimulus();
        checkOutput("trap_ack", {15'd0, bus.trap_pending}, 16'd0);
        bus.ss_load = 1'b1;
        applyStimulus();
        doRetire();
        checkOutput("trap_ss_inhibit", {15'd0, bus.trap_pending}, 16'd0);
        doRetire();
        checkOutput("trap_ss_inhibit2", {15'd0, bus.trap_pending}, 16'd0);
        doRetire();
        checkOutput("trap_after_shadow", {15'd0, bus.trap_pending}, 16'd1);
        bus.trap_ack    = 1'b1;
        bus.insn_retire = 1'b1;
        applyStimulus();
        checkOutput("trap_ack_wins", {15'd0, bus.trap_pending}, 16'd0);
        checkModel("trap");

        // Asynchronous reset mid-shadow with a trap pending.
        doRetire();
        doSet(3'd3);
        doRetire();
        checkOutput("pre_reset_trap", {15'd0, bus.trap_pending}, 16'd1);
        checkOutput("pre_reset_flags", bus.flags, 16'hF302);
        bus.cond = 4'h8;
        reset_n = 1'b0;
        #2;
        modelReset();
        checkOutput("async_flags", bus.flags, 16'hF002);
        checkOutput("async_int", {15'd0, bus.int_enabled}, 16'd0);
        checkOutput("async_trap", {15'd0, bus.trap_pending}, 16'd0);
        checkModel("async");
        #4;
        reset_n = 1'b1;
        doLoad(16'h0200);
        checkOutput("post_reset_shadow", {15'd0, bus.int_enabled}, 16'd1);
        doRetire();
        checkOutput("post_reset_armed", {15'd0, bus.trap_pending}, 16'd0);

        // Table of load values against Jcc conditions.
        vecs.push_back('{16'h0000, 4'h4, 16'hF002, 1'b0});
        vecs.push_back('{16'h0040, 4'h4, 16'hF042, 1'b1});
        vecs.push_back('{16'h0001, 4'h6, 16'hF003, 1'b1});
        vecs.push_back('{16'h0001, 4'h7, 16'hF003, 1'b0});
        vecs.push_back('{16'h0880, 4'hC, 16'hF882, 1'b0});
        vecs.push_back('{16'h0080, 4'hC, 16'hF082, 1'b1});
        vecs.push_back('{16'h0080, 4'hE, 16'hF082, 1'b1});
        vecs.push_back('{16'h0040, 4'hF, 16'hF042, 1'b0});
        vecs.push_back('{16'h0000, 4'hF, 16'hF002, 1'b1});
        vecs.push_back('{16'h0004, 4'hA, 16'hF006, 1'b1});
        vecs.push_back('{16'h0004, 4'hB, 16'hF006, 1'b0});
        vecs.push_back('{16'h0800, 4'h0, 16'hF802, 1'b1});
        vecs.push_back('{16'h0800, 4'h1, 16'hF802, 1'b0});
        vecs.push_back('{16'hFFFF, 4'hD, 16'hFFD7, 1'b1});
        vecs.push_back('{16'h0028, 4'h9, 16'hF002, 1'b1});
        vecs.push_back('{16'h0041, 4'h3, 16'hF043, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            bus.cond = vecs[i].cond;
            doLoad(vecs[i].load_val);
            checkOutput($sformatf("vec%0d.flags", i), bus.flags, vecs[i].exp_flags);
            checkOutput($sformatf("vec%0d.cond", i), {15'd0, bus.cond_true}, {15'd0, vecs[i].exp_cond});
            checkModel($sformatf("vec%0d", i));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.load        = ($urandom_range(0, 15) == 0);
            bus.load_val    = 16'($urandom);
            bus.alu_update  = 1'($urandom_range(0, 1));
            bus.alu_flags   = 16'($urandom);
            bus.update_mask = 16'($urandom);
            bus.set_en      = 1'($urandom_range(0, 1));
            bus.set_op      = 3'($urandom_range(0, 7));
            bus.ss_load     = ($urandom_range(0, 7) == 0);
            bus.insn_retire = ($urandom_range(0, 2) == 0);
            bus.trap_ack    = ($urandom_range(0, 5) == 0);
            bus.cond        = 4'($urandom_range(0, 15));
            applyStimulus();
            checkModel($sformatf("rand%0d", i));
            if ($urandom_range(0, 99) == 0) begin
                #1;
                reset_n = 1'b0;
                #1;
                modelReset();
                checkModel($sformatf("rand_reset%0d", i));
                reset_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
